// File: rtl/fp_norm_pkg.sv
// Shared widths, constants, beat payload and shift-decision helper for the normaliser pipe.
package fp_norm_pkg;

    localparam int unsigned MANT_W = 24;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned LZC_W  = 5;

    localparam logic [LZC_W-1:0] LZC_ZERO = 5'd31;
    localparam logic [EXP_W-1:0] EXP_MAX  = '1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic [LZC_W-1:0]  shift;
        logic              zero;
        logic              denorm;
    } norm_beat_t;

    // Decide shift amount and adjusted exponent; mantissa is carried unshifted.
    function automatic norm_beat_t norm_decide(
        input logic              sign,
        input logic [EXP_W-1:0]  exp,
        input logic [MANT_W-1:0] mant,
        input logic [LZC_W-1:0]  lzc
    );
        norm_beat_t      b;
        logic [EXP_W:0]  exp_x;
        logic [EXP_W:0]  lzc_x;
        logic [EXP_W:0]  diff;
        b      = '0;
        b.sign = sign;
        exp_x  = {1'b0, exp};
        lzc_x  = (EXP_W+1)'(lzc);
        diff   = exp_x - lzc_x;
        if (lzc >= LZC_W'(MANT_W)) begin
            // all-zero or out-of-range code: flush to a signed zero
            b.zero = 1'b1;
        end else if (exp == EXP_MAX) begin
            // Inf/NaN pass through untouched
            b.exp  = exp;
            b.mant = mant;
        end else if (exp == '0) begin
            // already denormal, nothing to absorb the shift
            b.mant = mant;
        end else if (exp_x > lzc_x) begin
            b.exp   = EXP_W'(diff);
            b.mant  = mant;
            b.shift = lzc;
        end else begin
            // shift only as far as the exponent reaches zero
            b.mant   = mant;
            b.shift  = LZC_W'(exp_x - (EXP_W+1)'(1));
            b.denorm = 1'b1;
        end
        return b;
    endfunction

endpackage

// File: rtl/fp_norm_shift_pipe_if.sv
// Upstream/downstream valid-ready bus of the normaliser pipe.
interface fp_norm_shift_pipe_if;
    import fp_norm_pkg::*;

    logic              i_valid;
    logic              o_ready;
    logic              i_sign;
    logic [EXP_W-1:0]  i_exp;
    logic [MANT_W-1:0] i_mant;
    logic [LZC_W-1:0]  i_lzc;
    logic              o_valid;
    logic              i_ready;
    logic              o_sign;
    logic [EXP_W-1:0]  o_exp;
    logic [MANT_W-1:0] o_mant;
    logic [LZC_W-1:0]  o_shift;
    logic              o_zero;
    logic              o_denorm;

    modport slave (
        input  i_valid, i_sign, i_exp, i_mant, i_lzc, i_ready,
        output o_ready, o_valid, o_sign, o_exp, o_mant, o_shift, o_zero, o_denorm
    );

    modport master (
        output i_valid, i_sign, i_exp, i_mant, i_lzc, i_ready,
        input  o_ready, o_valid, o_sign, o_exp, o_mant, o_shift, o_zero, o_denorm
    );

endinterface

// File: rtl/fp_lshift_24.sv
// Five-level logarithmic left barrel shifter, zero fill.
module fp_lshift_24
    import fp_norm_pkg::*;
(
    input  logic [MANT_W-1:0] mant,
    input  logic [LZC_W-1:0]  sh,
    output logic [MANT_W-1:0] mant_c
);

    logic [MANT_W-1:0] lvl [0:LZC_W];

    assign lvl[0] = mant;

    // Level k shifts by 2**k when sh[k] is set.
    for (genvar k = 0; k < LZC_W; k++) begin : g_lvl
        assign lvl[k+1] = sh[k] ? (lvl[k] << (2**k)) : lvl[k];
    end

    assign mant_c = lvl[LZC_W];

endmodule

// File: rtl/fp_norm_shift_pipe.sv
// Two-stage valid/ready normaliser: stage1 decides shift/exponent, stage2 applies the shift.
module fp_norm_shift_pipe
    import fp_norm_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    fp_norm_shift_pipe_if.slave bus
);

    norm_beat_t        s1_q;
    norm_beat_t        s2_q;
    norm_beat_t        s1_d;
    norm_beat_t        s2_d;
    logic              v1_q;
    logic              v2_q;
    logic              ready_c;
    logic              s2_en_c;
    logic [MANT_W-1:0] mant_sh_c;

    assign ready_c = ~v1_q | ~v2_q | bus.i_ready;
    assign s2_en_c = ~v2_q | bus.i_ready;

    // Shift decision on the incoming beat.
    always_comb begin
        s1_d = norm_decide(bus.i_sign, bus.i_exp, bus.i_mant, bus.i_lzc);
    end

    fp_lshift_24 u_shift (
        .mant   (s1_q.mant),
        .sh     (s1_q.shift),
        .mant_c (mant_sh_c)
    );

    // Stage1 payload with the mantissa replaced by its shifted value.
    always_comb begin
        s2_d      = s1_q;
        s2_d.mant = mant_sh_c;
    end

    // Stage1 register: accepts whenever the pipe can move.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v1_q <= 1'b0;
            s1_q <= '0;
        end else if (ready_c) begin
            v1_q <= bus.i_valid;
            if (bus.i_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Stage2 register: holds while the output is stalled.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v2_q <= 1'b0;
            s2_q <= '0;
        end else if (s2_en_c) begin
            v2_q <= v1_q;
            if (v1_q) begin
                s2_q <= s2_d;
            end
        end
    end

    assign bus.o_ready  = i_rst_n & ready_c;
    assign bus.o_valid  = v2_q;
    assign bus.o_sign   = s2_q.sign;
    assign bus.o_exp    = s2_q.exp;
    assign bus.o_mant   = s2_q.mant;
    assign bus.o_shift  = s2_q.shift;
    assign bus.o_zero   = s2_q.zero;
    assign bus.o_denorm = s2_q.denorm;

endmodule

// File: tb/tb_fp_norm_shift_pipe.sv
// Directed bench for the normaliser pipe: single beats, stalls, and reset flush.
module tb_fp_norm_shift_pipe;
    import fp_norm_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    fp_norm_shift_pipe_if bus ();

    fp_norm_shift_pipe dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] e,
                         input logic [23:0] m, input logic [4:0] l);
        bus.i_valid = v;
        bus.i_sign  = s;
        bus.i_exp   = e;
        bus.i_mant  = m;
        bus.i_lzc   = l;
    endtask

    task automatic chk_beat(input string tag, input logic s, input logic [7:0] e,
                            input logic [23:0] m, input logic [4:0] sh,
                            input logic z, input logic d);
        chk({tag, "_valid"},  32'(bus.o_valid),  32'd1);
        chk({tag, "_sign"},   32'(bus.o_sign),   32'(s));
        chk({tag, "_exp"},    32'(bus.o_exp),    32'(e));
        chk({tag, "_mant"},   32'(bus.o_mant),   32'(m));
        chk({tag, "_shift"},  32'(bus.o_shift),  32'(sh));
        chk({tag, "_zero"},   32'(bus.o_zero),   32'(z));
        chk({tag, "_denorm"}, 32'(bus.o_denorm), 32'(d));
    endtask

    // One beat with i_ready=1: not valid after 1 edge, valid after 2, gone after 3.
    task automatic run_one(input string tag, input logic s, input logic [7:0] e,
                           input logic [23:0] m, input logic [4:0] l,
                           input logic [7:0] xe, input logic [23:0] xm,
                           input logic [4:0] xsh, input logic xz, input logic xd);
        drive(1'b1, s, e, m, l);
        step();
        drive(1'b0, 1'b0, 8'd0, 24'd0, 5'd0);
        chk({tag, "_lat1"}, 32'(bus.o_valid), 32'd0);
        step();
        chk_beat(tag, s, xe, xm, xsh, xz, xd);
        step();
        chk({tag, "_drain"}, 32'(bus.o_valid), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.i_ready = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 24'd0, 5'd0);
        step();
        step();

        // reset state
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_ready", 32'(bus.o_ready), 32'd0);
        chk("rst_mant",  32'(bus.o_mant),  32'd0);
        chk("rst_exp",   32'(bus.o_exp),   32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(bus.o_ready), 32'd1);
        step();

        // single beats across every shift-decision branch
        run_one("norm8",   1'b0, 8'd100, 24'h008000, 5'd8,  8'd92,  24'h800000, 5'd8,  1'b0, 1'b0);
        run_one("zero",    1'b1, 8'd50,  24'h000000, 5'd31, 8'd0,   24'h000000, 5'd0,  1'b1, 1'b0);
        run_one("clamp",   1'b0, 8'd10,  24'h000001, 5'd23, 8'd0,   24'h000200, 5'd9,  1'b0, 1'b1);
        run_one("edge24",  1'b1, 8'd24,  24'h000001, 5'd23, 8'd1,   24'h800000, 5'd23, 1'b0, 1'b0);
        run_one("infnan",  1'b0, 8'd255, 24'h400000, 5'd1,  8'd255, 24'h400000, 5'd0,  1'b0, 1'b0);
        run_one("exp0",    1'b0, 8'd0,   24'h001234, 5'd11, 8'd0,   24'h001234, 5'd0,  1'b0, 1'b0);
        run_one("expeq",   1'b0, 8'd8,   24'h008000, 5'd8,  8'd0,   24'h400000, 5'd7,  1'b0, 1'b1);
        run_one("expgt",   1'b0, 8'd9,   24'h008000, 5'd8,  8'd1,   24'h800000, 5'd8,  1'b0, 1'b0);
        run_one("badlzc",  1'b1, 8'd77,  24'hABCDEF, 5'd24, 8'd0,   24'h000000, 5'd0,  1'b1, 1'b0);
        run_one("nosh",    1'b0, 8'd130, 24'h800000, 5'd0,  8'd130, 24'h800000, 5'd0,  1'b0, 1'b0);

        // back-to-back beats with downstream stalled
        bus.i_ready = 1'b0;
        drive(1'b1, 1'b0, 8'd40, 24'h800000, 5'd0);
        #1;
        chk("bp_rdy0", 32'(bus.o_ready), 32'd1);
        step();
        drive(1'b1, 1'b0, 8'd41, 24'h800001, 5'd0);
        #1;
        chk("bp_rdy1", 32'(bus.o_ready), 32'd1);
        step();
        drive(1'b1, 1'b0, 8'd42, 24'h800002, 5'd0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_full_rdy", 32'(bus.o_ready), 32'd0);
            chk("bp_hold_vld", 32'(bus.o_valid), 32'd1);
            chk("bp_hold_exp", 32'(bus.o_exp),   32'd40);
            chk("bp_hold_man", 32'(bus.o_mant),  32'h800000);
            step();
        end
        bus.i_ready = 1'b1;
        #1;
        chk("bp_rdy_rel", 32'(bus.o_ready), 32'd1);
        chk_beat("bp0", 1'b0, 8'd40, 24'h800000, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 8'd43, 24'h800003, 5'd0);
        chk_beat("bp1", 1'b0, 8'd41, 24'h800001, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'd0, 24'd0, 5'd0);
        chk_beat("bp2", 1'b0, 8'd42, 24'h800002, 5'd0, 1'b0, 1'b0);
        step();
        chk_beat("bp3", 1'b0, 8'd43, 24'h800003, 5'd0, 1'b0, 1'b0);
        step();
        chk("bp_empty", 32'(bus.o_valid), 32'd0);

        // reset with two beats in flight
        drive(1'b1, 1'b0, 8'd60, 24'h010000, 5'd7);
        step();
        drive(1'b1, 1'b1, 8'd61, 24'h020000, 5'd6);
        step();
        drive(1'b0, 1'b0, 8'd0, 24'd0, 5'd0);
        rst_n = 1'b0;
        #1;
        chk("fl_rst_rdy", 32'(bus.o_ready), 32'd0);
        step();
        chk("fl_vld0",  32'(bus.o_valid), 32'd0);
        chk("fl_mant0", 32'(bus.o_mant),  32'd0);
        rst_n = 1'b1;
        #1;
        chk("fl_rel_rdy", 32'(bus.o_ready), 32'd1);
        step();
        chk("fl_vld1", 32'(bus.o_valid), 32'd0);
        step();
        chk("fl_vld2", 32'(bus.o_valid), 32'd0);
        run_one("post", 1'b1, 8'd100, 24'h008000, 5'd8, 8'd92, 24'h800000, 5'd8, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
